// File: rtl/seg7_pkg.sv
// Shared constants, types and helpers for the 4-digit seven-segment scanner
// and the downstream anode-enable decoder.
package seg7_pkg;

  localparam int NUM_DIGITS       = 4;
  localparam int DIGIT_W          = 2;
  localparam int NIBBLE_W         = 4;
  localparam int DATA_W           = NUM_DIGITS * NIBBLE_W;
  localparam int PRESCALE_DEFAULT = 50000;
  localparam int DEADTIME_DEFAULT = 16;

  typedef logic [DIGIT_W-1:0]  digit_t;
  typedef logic [NIBBLE_W-1:0] nibble_t;

  // One complete display image: four hex nibbles plus their decimal points.
  typedef struct packed {
    logic [DATA_W-1:0]     data;
    logic [NUM_DIGITS-1:0] dp;
  } frame_t;

  // Hex value of digit idx within a packed 16-bit image.
  function automatic nibble_t sel_nibble(logic [DATA_W-1:0] data, digit_t idx);
    return data[idx*NIBBLE_W +: NIBBLE_W];
  endfunction

  // Leading-zero rule: digit idx goes dark when it and every digit above it
  // are zero. Digit 0 always shows, and a lit decimal point keeps its digit on.
  function automatic logic lead_zero(frame_t img, digit_t idx);
    logic all_zero;
    all_zero = 1'b1;
    for (int n = 0; n < NUM_DIGITS; n++) begin
      if (n >= int'(idx) && img.data[n*NIBBLE_W +: NIBBLE_W] != '0) begin
        all_zero = 1'b0;
      end
    end
    return (idx != '0) && all_zero && !img.dp[idx];
  endfunction

endpackage

// File: rtl/seg7_tick.sv
// Digit-slot prescaler: counts 0..PRESCALE-1 and flags the last count.
module seg7_tick
  import seg7_pkg::*;
#(
  parameter int PRESCALE = PRESCALE_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick_o
);

  localparam int            CW   = $clog2(PRESCALE);
  localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_next;

  // Wrapping increment of the slot counter.
  always_comb begin
    cnt_next = (cnt == LAST) ? '0 : cnt + CW'(1);
  end

  // Counter plus a registered tick that is high while the count sits at LAST,
  // so the consumer sees a clean flop output rather than a compare.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      tick_o <= 1'b0;
    end else begin
      // NOTE: state is updated with non-blocking assignments so every flop
      // samples pre-edge values; blocking here would create ordering races.
      cnt    <= cnt_next;
      tick_o <= (cnt_next == LAST);
    end
  end

endmodule

// File: rtl/seg7_scan.sv
// Four-digit multiplexed seven-segment scanner. Walks the digit index at a
// fixed slot rate, double-buffers loaded values so an image only changes at
// frame boundaries, and drives blanking for dead-time and leading zeros.
module seg7_scan
  import seg7_pkg::*;
#(
  parameter int PRESCALE = PRESCALE_DEFAULT,
  parameter int DEADTIME = DEADTIME_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load_i,
  input  logic [DATA_W-1:0]     data_i,
  input  logic [NUM_DIGITS-1:0] dp_i,
  input  logic                  blankz_i,
  output logic [DIGIT_W-1:0]    oe_digit_o,
  output logic [NIBBLE_W-1:0]   nibble_o,
  output logic                  dp_o,
  output logic                  blank_o,
  output logic                  pending_o,
  output logic                  frame_o
);

  // Wide enough to hold DEADTIME, and never zero bits wide.
  localparam int            DW        = $clog2(DEADTIME + 2);
  localparam logic [DW-1:0] DEAD_LOAD = DW'(DEADTIME);
  localparam digit_t        LAST_DIG  = digit_t'(NUM_DIGITS - 1);

  logic    tick;
  logic    commit;
  digit_t  digit_next;
  frame_t  shadow_q;
  frame_t  disp_q;
  frame_t  disp_next;
  frame_t  load_img;
  logic [DW-1:0] dead_q;
  logic [DW-1:0] dead_next;

  seg7_tick #(
    .PRESCALE (PRESCALE)
  ) u_tick (
    .clk    (clk),
    .rst_n  (rst_n),
    .tick_o (tick)
  );

  // Next-state view of digit index, display image and dead-time counter, so
  // the registered outputs can track the new digit on the edge it changes.
  always_comb begin
    // NOTE: every signal gets a default before the conditionals; a path that
    // leaves one unassigned would infer a latch.
    load_img.data = data_i;
    load_img.dp   = dp_i;
    commit        = tick && (oe_digit_o == LAST_DIG);
    digit_next    = tick ? oe_digit_o + digit_t'(1) : oe_digit_o;
    disp_next     = disp_q;
    dead_next     = dead_q;

    // A load on the commit edge bypasses the shadow so it is not a frame late.
    if (commit) begin
      if (load_i) begin
        disp_next = load_img;
      end else if (pending_o) begin
        disp_next = shadow_q;
      end
    end

    if (tick) begin
      dead_next = DEAD_LOAD;
    end else if (dead_q != '0) begin
      dead_next = dead_q - DW'(1);
    end
  end

  // Scan state, double buffer and registered display outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      oe_digit_o <= '0;
      shadow_q   <= '0;
      disp_q     <= '0;
      pending_o  <= 1'b0;
      dead_q     <= DEAD_LOAD;
      nibble_o   <= '0;
      dp_o       <= 1'b0;
      blank_o    <= 1'b1;
      frame_o    <= 1'b0;
    end else begin
      oe_digit_o <= digit_next;
      disp_q     <= disp_next;
      dead_q     <= dead_next;
      frame_o    <= commit;

      if (load_i) begin
        shadow_q <= load_img;
      end

      // Commit always empties the shadow: either it was just copied, or a
      // coincident load went straight to the display.
      if (commit) begin
        pending_o <= 1'b0;
      end else if (load_i) begin
        pending_o <= 1'b1;
      end

      // Value and decimal point stay live under blanking so the segment
      // decoder never sees a glitch when blanking lifts.
      nibble_o <= sel_nibble(disp_next.data, digit_next);
      dp_o     <= disp_next.dp[digit_next];
      blank_o  <= (dead_next != '0) ||
                  (blankz_i && lead_zero(disp_next, digit_next));
    end
  end

endmodule
